// File: rtl/div_pkg.sv
// Shared types and constants for the multicycle divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = DIV_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, try to subtract the divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);

  // One extra bit: the shifted remainder can exceed WIDTH bits when the divisor is >= 2^(WIDTH-1).
  logic [WIDTH:0] shifted;

  assign shifted  = {rem, dvd_msb};
  assign q_bit    = (shifted >= {1'b0, divisor});
  assign next_rem = q_bit ? WIDTH'(shifted - {1'b0, divisor}) : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Multicycle signed restoring divider for DIV: quotient on lo, remainder on hi.
// Define DIV_UNSIGNED_EN to add the divu input for unsigned (DIVU) operation.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef DIV_UNSIGNED_EN
  input  logic             divu,
`endif
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div0
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | one restoring iteration per cycle
  // FIX   | apply result signs, load hi/lo
  // DONE  | one-cycle done pulse (with div0 if divisor was zero)

  div_state_e       state, state_next;
  logic [WIDTH-1:0] rem, dvd, dvs, next_rem;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [CNT_W-1:0] cnt;
  logic             sign_q, sign_r, div0_flag, q_bit, is_signed;

`ifdef DIV_UNSIGNED_EN
  assign is_signed = ~divu;
`else
  assign is_signed = 1'b1;
`endif

  // Magnitudes are treated as unsigned, so the most negative value maps onto itself.
  assign mag_a = (is_signed && a[WIDTH-1]) ? -a : a;
  assign mag_b = (is_signed && b[WIDTH-1]) ? -b : b;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .dvd_msb (dvd[WIDTH-1]),
    .divisor (dvs),
    .next_rem(next_rem),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (b == '0) ? DONE : RUN;
      RUN:     if (cnt == CNT_W'(1)) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign div0 = done & div0_flag;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rem       <= '0;
      dvd       <= '0;
      dvs       <= '0;
      cnt       <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      div0_flag <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            div0_flag <= (b == '0);
            if (b != '0) begin
              dvd    <= mag_a;
              dvs    <= mag_b;
              rem    <= '0;
              cnt    <= CNT_W'(WIDTH);
              sign_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
              sign_r <= is_signed & a[WIDTH-1];
            end
          end
        end
        RUN: begin
          rem <= next_rem;
          dvd <= {dvd[WIDTH-2:0], q_bit};
          cnt <= cnt - CNT_W'(1);
        end
        FIX: begin
          lo <= sign_q ? -dvd : dvd;
          hi <= sign_r ? -rem : rem;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: vector table plus busy/reset corner sequences.
module tb_div_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] hi, lo;
  logic        busy, done, div0;

  int n_checks = 0;
  int n_fail   = 0;

  div_unit dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .a    (a),
    .b    (b),
    .hi   (hi),
    .lo   (lo),
    .busy (busy),
    .done (done),
    .div0 (div0)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        div0;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Pulses start, then waits (bounded) for done; lat counts cycles after the sampling edge.
  task automatic run_div(input logic [31:0] av, input logic [31:0] bv, output int lat);
    a     = av;
    b     = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  vec_t vecs[12];

  initial begin
    int lat;
    int ndone;
    logic [31:0] cap_lo, cap_hi;

    vecs[0]  = '{32'd7,        32'd2,        32'd3,        32'd1,        1'b0, 33};
    vecs[1]  = '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33};
    vecs[2]  = '{32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 33};
    vecs[3]  = '{32'd5,        32'd0,        32'hFFFFFFFD, 32'd1,        1'b1, 0};
    vecs[4]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 33};
    vecs[5]  = '{32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0, 33};
    vecs[6]  = '{32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 33};
    vecs[7]  = '{32'hFFFFFFFF, 32'h80000000, 32'd0,        32'hFFFFFFFF, 1'b0, 33};
    vecs[8]  = '{32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 32'd0,        1'b0, 33};
    vecs[9]  = '{32'h80000000, 32'h80000000, 32'd1,        32'd0,        1'b0, 33};
    vecs[10] = '{32'h12345678, 32'h00000100, 32'h00123456, 32'h00000078, 1'b0, 33};
    vecs[11] = '{32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 33};

    #12;
    check("rst_hi",   hi,   32'd0);
    check("rst_lo",   lo,   32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_div0", {31'd0, div0}, 32'd0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      run_div(vecs[i].a, vecs[i].b, lat);
      check($sformatf("v%0d_lat", i),  lat,  vecs[i].lat);
      check($sformatf("v%0d_done", i), {31'd0, done}, 32'd1);
      check($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
      check($sformatf("v%0d_div0", i), {31'd0, div0}, {31'd0, vecs[i].div0});
      check($sformatf("v%0d_lo", i),   lo,   vecs[i].lo);
      check($sformatf("v%0d_hi", i),   hi,   vecs[i].hi);
      tick();
      check($sformatf("v%0d_done_off", i), {31'd0, done}, 32'd0);
      check($sformatf("v%0d_busy_off", i), {31'd0, busy}, 32'd0);
      check($sformatf("v%0d_div0_off", i), {31'd0, div0}, 32'd0);
      tick();
    end

    // Second start and operand changes while busy must be ignored.
    a = 32'd1000; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0; lat = -1; cap_lo = '0; cap_hi = '0;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      if (cyc == 10) begin
        a = 32'd50; b = 32'd5; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          lat = cyc; cap_lo = lo; cap_hi = hi;
        end
      end
    end
    check("busy_start_ndone", ndone,  32'd1);
    check("busy_start_lat",   lat,    32'd33);
    check("busy_start_lo",    cap_lo, 32'd333);
    check("busy_start_hi",    cap_hi, 32'd1);

    // Reset mid-division aborts at once and clears results.
    a = 32'd1000; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    reset = 1'b0;
    #1;
    check("abort_hi",   hi,   32'd0);
    check("abort_lo",   lo,   32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    ndone = 0;
    repeat (3) begin
      tick();
      if (done) ndone++;
    end
    reset = 1'b1;
    repeat (2) begin
      tick();
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 32'd0);
    run_div(32'd100, 32'd7, lat);
    check("post_rst_lat", lat, 32'd33);
    check("post_rst_lo",  lo,  32'd14);
    check("post_rst_hi",  hi,  32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multicycle signed 32-bit divider serving the DIV instruction of the multicycle MIPS core.
- Acts as the responder to the control unit's divide request: the control unit pulses start with operands A and B, then waits for done.
- Quotient feeds the LO path and remainder feeds the HI path through the div/mult select mux.
- Raises a divide-by-zero flag that the control unit routes into its exception sequence.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request pulse from control unit; sampled only in IDLE.
- a  input  WIDTH  dividend (register A).
- b  input  WIDTH  divisor (register B).
- hi  output  WIDTH  remainder, registered.
- lo  output  WIDTH  quotient, registered.
- busy  output  1  high from the start-sampling edge until done drops.
- done  output  1  one-cycle completion pulse.
- div0  output  1  divide-by-zero flag; pulses together with done.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- While reset=0: state=IDLE; hi, lo, busy, done, div0 and all internal registers are 0.
- States: IDLE, RUN, FIX, DONE.
- IDLE, edge E0 with start=1 and b!=0:
  - latch |a| into the dividend shift register and |b| into the divisor register; magnitudes are unsigned, so 0x80000000 stays 0x80000000;
  - latch sign_q = a[31]^b[31] and sign_r = a[31];
  - clear the partial remainder; set counter=WIDTH; go to RUN.
- IDLE, edge E0 with start=1 and b==0: go to DONE with div0_next=1; hi and lo keep their previous values.
- RUN: one restoring iteration per edge.
  - Shift {rem, dvd} left 1 bit.
  - trial = rem - divisor; if trial is non-negative, rem=trial and quotient bit=1, else the quotient bit is 0.
  - Decrement counter; when it reaches 0 (edge E32), go to FIX.
- FIX, edge E33:
  - lo = sign_q ? -q : q; hi = sign_r ? -rem : rem; go to DONE.
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
- DONE: done=1 (and div0=1 if flagged) for exactly one cycle, then return to IDLE. Normal done appears in the cycle following E33; div-by-zero done appears in the cycle following E0.
- busy=1 in RUN, FIX and DONE; busy=0 in IDLE.
- start while busy is ignored; no queuing.
- Overflow case: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000 (wraps), hi=0, div0=0. No overflow exception is raised.
- hi and lo hold their values until the next successful completion. A, B changes after E0 have no effect.
- Reset asserted mid-operation aborts immediately; outputs return to 0 and no done is emitted.

Optional Feature:
- Macro DIV_UNSIGNED_EN.
- When defined: adds input port divu (1 bit), sampled at E0. With divu=1, the magnitudes are a and b unsigned, sign_q=sign_r=0, and FIX passes results unchanged (DIVU semantics). Latency and the div0 rule are unchanged.
- When undefined: the port is absent and all divisions are signed.

Decomposition:
- Package div_pkg holds: the state enum (IDLE, RUN, FIX, DONE); the WIDTH default constant; the localparam for iteration count.
- Sub-module div_step: combinational single restoring iteration, taking rem, dvd_msb and divisor and producing next_rem and q_bit. It is instantiated once inside div_unit.

Test Plan:
- a=7, b=2, start pulse -> done exactly 33 cycles after the sampling edge; lo=0x00000003, hi=0x00000001, div0=0.
- a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); repeat with a=7, b=-2 -> lo=0xFFFFFFFD, hi=0x00000001.
- After a previous result, a=5, b=0 -> done=1 and div0=1 in the cycle after the sampling edge; hi/lo unchanged; busy drops the next cycle.
- a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000, div0=0.
- Second start pulse at cycle 10 of a running division (with different a/b) -> ignored; first result delivered unchanged; only one done pulse.
- reset driven low at cycle 15 of a division -> hi=lo=0, busy=0, done=0 immediately. After release, a new start of 100/7 -> lo=14, hi=2.
